div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_pkg.sv | 14 +
 rtl/rr_arb2.sv | 35 +++
 rtl/div_arbiter.sv | 140 ++++++++++++++
 tb/tb_div_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared FSM encoding and constants for the divider request arbiter.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    // Divide-by-zero quotient is all ones; replicated to the operand width at use.
    localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; requester 0 wins first after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt0,
    output logic gnt1
);

    logic last_gnt;

    // Pointer only moves on an accepted grant, so a withdrawn request leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= 1'b1;
        end else if (take) begin
            last_gnt <= gnt1;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates two requesters onto one external divider, one operation in flight,
// with divide-by-zero bypass and a bounded wait for the divider result.
//
// state    | meaning
// ST_IDLE  | accept one request from the round-robin winner
// ST_ISSUE | one-cycle div_valid pulse to the divider
// ST_WAIT  | wait for div_ready or TMO cycles, whichever comes first
// ST_RESP  | hold response until resp_ready
module div_arbiter
    import div_pkg::*;
#(
    parameter int WID = 64,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [WID-1:0] req0_dividend,
    input  logic [WID-1:0] req0_divisor,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [WID-1:0] req1_dividend,
    input  logic [WID-1:0] req1_divisor,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [WID-1:0] resp_quotient,
    output logic [WID-1:0] resp_remainder,
    output logic           resp_dbz,
    output logic           resp_tmo,
    output logic           div_valid,
    output logic [WID-1:0] div_dividend,
    output logic [WID-1:0] div_divisor,
    input  logic           div_ready,
    input  logic [WID-1:0] div_quotient,
    input  logic [WID-1:0] div_remainder
);

    localparam int            CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    div_state_e     state, state_nx;
    logic           idle, xfer, sel_id, sel_dbz, tmo_hit;
    logic [WID-1:0] sel_dvd, sel_dvs, dvd_q, dvs_q;
    logic           id_q;
    logic [CW-1:0]  wait_cnt;

    assign idle = (state == ST_IDLE);

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0_valid && idle),
        .req1 (req1_valid && idle),
        .take (xfer),
        .gnt0 (req0_ready),
        .gnt1 (req1_ready)
    );

    assign xfer    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_id  = req1_valid && req1_ready;
    assign sel_dvd = sel_id ? req1_dividend : req0_dividend;
    assign sel_dvs = sel_id ? req1_divisor  : req0_divisor;
    assign sel_dbz = (sel_dvs == '0);
    // wait_cnt counts completed WAIT cycles; the last allowed one is TMO-1.
    assign tmo_hit = (wait_cnt == TMO_LAST);

    assign div_valid    = (state == ST_ISSUE);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign resp_valid   = (state == ST_RESP);
    assign resp_id      = id_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (xfer) state_nx = sel_dbz ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (div_ready || tmo_hit) state_nx = ST_RESP;
            ST_RESP:  if (resp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q          <= '0;
            dvs_q          <= '0;
            id_q           <= 1'b0;
            wait_cnt       <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_dbz       <= 1'b0;
            resp_tmo       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        dvd_q <= sel_dvd;
                        dvs_q <= sel_dvs;
                        id_q  <= sel_id;
                        if (sel_dbz) begin
                            resp_quotient  <= {WID{DBZ_QUOT_BIT}};
                            resp_remainder <= sel_dvd;
                            resp_dbz       <= 1'b1;
                            resp_tmo       <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    if (div_ready) begin
                        resp_quotient  <= div_quotient;
                        resp_remainder <= div_remainder;
                        resp_dbz       <= 1'b0;
                        resp_tmo       <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_quotient  <= '0;
                        resp_remainder <= '0;
                        resp_dbz       <= 1'b0;
                        resp_tmo       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: transaction-level reference model with a scripted divider,
// directed scenarios followed by randomized traffic.
module tb_div_arbiter;

    localparam int WID = 64;
    localparam int TMO = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WID-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
    logic           resp_valid, resp_ready, resp_id, resp_dbz, resp_tmo;
    logic [WID-1:0] resp_quotient, resp_remainder;
    logic           div_valid, div_ready;
    logic [WID-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

    div_arbiter #(.WID(WID), .TMO(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_dividend  (req0_dividend),
        .req0_divisor   (req0_divisor),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_dividend  (req1_dividend),
        .req1_divisor   (req1_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dbz       (resp_dbz),
        .resp_tmo       (resp_tmo),
        .div_valid      (div_valid),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_ready      (div_ready),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Pending requester operations
    logic        pend [2];
    logic [63:0] p_dvd[2];
    logic [63:0] p_dvs[2];

    // Reference model: one operation in flight, timed from its transfer cycle t0
    logic        m_busy, m_last, m_id, m_dbz, m_tmo;
    int          m_t0, m_lat, m_resp_cyc;
    logic [63:0] m_dvd, m_dvs, m_q, m_r;

    // Stimulus knobs
    logic gen_en, drop_en, spur_en, rr_rand, late_rdy, refill;
    int   fix_lat, rr_block, n_issue;
    logic served[$];
    logic last_tmo;

    task automatic new_op(input int i);
        pend[i] = 1'b1;
        p_dvd[i] = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 5000)) : {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       p_dvs[i] = 64'd0;
            1, 2:    p_dvs[i] = 64'($urandom_range(1, 100));
            3:       p_dvs[i] = {32'h0, $urandom} | 64'd1;
            default: p_dvs[i] = {$urandom, $urandom} | 64'd1;
        endcase
    endtask

    // Divider answers lat cycles after div_valid; beyond TMO it never answers in time.
    task automatic start_op(input logic g);
        m_busy = 1'b1;
        m_last = g;
        m_id   = g;
        m_dvd  = p_dvd[g];
        m_dvs  = p_dvs[g];
        if (!refill) pend[g] = 1'b0;
        m_t0   = cyc;
        m_dbz  = (m_dvs == 64'd0);
        m_lat  = (fix_lat > 0) ? fix_lat :
                 (($urandom_range(0, 4) == 0) ? TMO - 2 + int'($urandom_range(0, 4)) : int'($urandom_range(1, 5)));
        m_tmo  = 1'b0;
        if (m_dbz) begin
            m_q = '1;
            m_r = m_dvd;
            m_resp_cyc = cyc + 1;
        end else if (m_lat > TMO) begin
            m_tmo = 1'b1;
            m_q = 64'd0;
            m_r = 64'd0;
            m_resp_cyc = cyc + 2 + TMO;
        end else begin
            m_q = m_dvd / m_dvs;
            m_r = m_dvd % m_dvs;
            m_resp_cyc = cyc + 2 + m_lat;
        end
    endtask

    task automatic step();
        logic v0, v1, g, exp_rv, in_wait;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++)
            if (gen_en && !pend[i] && $urandom_range(0, 3) == 0) new_op(i);
        v0 = pend[0] && !(drop_en && $urandom_range(0, 7) == 0);
        v1 = pend[1] && !(drop_en && $urandom_range(0, 7) == 0);
        req0_valid = v0; req0_dividend = p_dvd[0]; req0_divisor = p_dvs[0];
        req1_valid = v1; req1_dividend = p_dvd[1]; req1_divisor = p_dvs[1];
        exp_rv = m_busy && (cyc >= m_resp_cyc);
        if (exp_rv && rr_block > 0) begin
            resp_ready = 1'b0;
            rr_block--;
        end else begin
            resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        in_wait = m_busy && !m_dbz && (cyc >= m_t0 + 2) && (cyc < m_resp_cyc);
        div_quotient  = {$urandom, $urandom};
        div_remainder = {$urandom, $urandom};
        if (in_wait && m_lat <= TMO && cyc == m_t0 + 1 + m_lat) begin
            div_ready     = 1'b1;
            div_quotient  = m_q;
            div_remainder = m_r;
        end else begin
            div_ready = !in_wait && (late_rdy || (spur_en && $urandom_range(0, 3) == 0));
        end
        #1;
        if (div_valid) n_issue++;
        g = (v0 && v1) ? !m_last : v1;
        chk("req0_ready", req0_ready, !m_busy && v0 && !g);
        chk("req1_ready", req1_ready, !m_busy && v1 && g);
        chk("div_valid", div_valid, m_busy && !m_dbz && cyc == m_t0 + 1);
        if (m_busy && !m_dbz && cyc > m_t0 && cyc < m_resp_cyc) begin
            chk("div_dividend", div_dividend, m_dvd);
            chk("div_divisor", div_divisor, m_dvs);
        end
        chk("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            chk("resp_id", resp_id, m_id);
            chk("resp_quotient", resp_quotient, m_q);
            chk("resp_remainder", resp_remainder, m_r);
            chk("resp_dbz", resp_dbz, m_dbz);
            chk("resp_tmo", resp_tmo, m_tmo);
        end
        if (m_busy) begin
            if (exp_rv && resp_ready) begin
                m_busy = 1'b0;
                served.push_back(resp_id);
                last_tmo = resp_tmo;
            end
        end else if (v0 || v1) begin
            start_op(g);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((m_busy || pend[0] || pend[1]) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_completes"}, m_busy || pend[0] || pend[1], 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        div_ready = 1'b0;
        m_busy = 1'b0; m_last = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_div_valid", div_valid, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_dbz", resp_dbz, 1'b0);
        chk("rst_resp_tmo", resp_tmo, 1'b0);
        chk("rst_resp_id", resp_id, 1'b0);
        chk("rst_resp_quotient", resp_quotient, 64'd0);
        chk("rst_resp_remainder", resp_remainder, 64'd0);
        chk("rst_div_dividend", div_dividend, 64'd0);
        chk("rst_div_divisor", div_divisor, 64'd0);
        repeat (hold) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic put(input int i, input logic [63:0] a, input logic [63:0] b);
        pend[i] = 1'b1;
        p_dvd[i] = a;
        p_dvs[i] = b;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 0; req1_valid = 0; resp_ready = 0; div_ready = 0;
        req0_dividend = 0; req0_divisor = 0; req1_dividend = 0; req1_divisor = 0;
        div_quotient = 0; div_remainder = 0;
        pend[0] = 0; pend[1] = 0;
        p_dvd[0] = 0; p_dvd[1] = 0; p_dvs[0] = 0; p_dvs[1] = 0;
        m_busy = 0; m_last = 1; m_t0 = 0; m_lat = 0; m_resp_cyc = 0;
        gen_en = 0; drop_en = 0; spur_en = 0; rr_rand = 0; late_rdy = 0; refill = 0;
        fix_lat = 0; rr_block = 0; n_issue = 0; last_tmo = 0;
        do_reset(3);

        // Simultaneous requests alternate, requester 0 first after reset
        served.delete();
        put(0, 64'd100, 64'd7);
        put(1, 64'd50, 64'd5);
        refill = 1; fix_lat = 2;
        for (int n = 0; n < 200 && served.size() < 4; n++) step();
        refill = 0;
        drain("alternate", 100);
        chk("alt_count", 64'(served.size() >= 4), 1'b1);
        if (served.size() >= 4) begin
            chk("alt_first", served[0], 1'b0);
            chk("alt_second", served[1], 1'b1);
            chk("alt_third", served[2], 1'b0);
            chk("alt_fourth", served[3], 1'b1);
        end

        // Single request, one divider pulse
        n_issue = 0; fix_lat = 3;
        put(0, 64'd11, 64'd3);
        drain("single", 50);
        chk("single_issue_pulses", n_issue, 1);

        // Divide-by-zero bypasses the divider
        n_issue = 0;
        put(1, 64'd42, 64'd0);
        drain("dbz", 50);
        chk("dbz_issue_pulses", n_issue, 0);

        // Backpressure on the response while the other requester waits
        n_issue = 0; rr_block = 5;
        put(0, 64'd77, 64'd8);
        step();
        put(1, 64'd9, 64'd2);
        drain("backpressure", 100);
        chk("bp_issue_pulses", n_issue, 2);

        // Divider answering on the last allowed WAIT cycle is not a timeout
        fix_lat = TMO;
        put(0, 64'd300, 64'd4);
        drain("tmo_edge", 100);
        chk("tmo_edge_flag", last_tmo, 1'b0);

        // Stalled divider times out
        fix_lat = TMO + 1;
        put(1, 64'd500, 64'd3);
        drain("timeout", 100);
        chk("timeout_flag", last_tmo, 1'b1);

        // Reset mid-WAIT, then a stale div_ready must not produce a response
        fix_lat = 1000;
        put(0, 64'd1000, 64'd7);
        for (int n = 0; n < 20 && !(m_busy && cyc >= m_t0 + 5); n++) step();
        chk("reached_wait", m_busy && cyc >= m_t0 + 5, 1'b1);
        do_reset(2);
        late_rdy = 1;
        repeat (3) step();
        late_rdy = 0;
        repeat (4) step();
        chk("late_rdy_no_resp", resp_valid, 1'b0);
        fix_lat = 0;

        // Randomized traffic
        gen_en = 1; drop_en = 1; spur_en = 1; rr_rand = 1;
        repeat (3000) step();
        gen_en = 0;
        drain("random", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
